// File: rtl/wb_serial_master_pkg.sv
// rtl/wb_serial_master_pkg.sv - shared constants, state encoding and helpers for the serial Wishbone master
package wb_serial_master_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h45;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        BUS  = 3'd3,
        RESP = 3'd4
    } state_e;

    // Byte idx of a word, counted MSB first (idx 0 is bits 31:24).
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    word_byte = w[31:24];
            2'd1:    word_byte = w[23:16];
            2'd2:    word_byte = w[15:8];
            default: word_byte = w[7:0];
        endcase
    endfunction

endpackage

// File: rtl/wb_serial_master_if.sv
// rtl/wb_serial_master_if.sv - Wishbone classic bus bundle between the serial master and the interconnect
interface wb_serial_master_if;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        wb_rty_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );
endinterface

// File: rtl/wb_serial_timer.sv
// rtl/wb_serial_timer.sv - saturating cycle counter; expire_o holds once LIMIT-1 is reached
module wb_serial_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/wb_serial_master.sv
// rtl/wb_serial_master.sv - byte-stream command parser driving single Wishbone classic cycles
module wb_serial_master
    import wb_serial_master_pkg::*;
#(
    parameter int timeout_cycles = 1024,
    parameter int rx_gap_cycles  = 100000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    wb_serial_master_if.master        wb,
    output logic                      busy
);

    state_e      state_q, state_d;
    logic        is_write_q, is_write_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdat_q, wdat_d;
    logic [31:0] rdat_q, rdat_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic        rsp_multi_q, rsp_multi_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;

    logic in_cmd;
    logic in_bus;
    logic bus_expire;
    logic gap_expire;

    assign in_cmd = (state_q == ADDR) || (state_q == DATA);
    assign in_bus = (state_q == BUS);

    wb_serial_timer #(.LIMIT(timeout_cycles)) u_bus_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .en_i     (in_bus),
        .clr_i    (!in_bus),
        .expire_o (bus_expire)
    );

    // Any received byte restarts the inter-byte gap window.
    wb_serial_timer #(.LIMIT(rx_gap_cycles)) u_gap_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .en_i     (in_cmd),
        .clr_i    (!in_cmd || rx_valid),
        .expire_o (gap_expire)
    );

    always_comb begin
        state_d     = state_q;
        is_write_d  = is_write_q;
        byte_cnt_d  = byte_cnt_q;
        adr_d       = adr_q;
        wdat_d      = wdat_q;
        rdat_d      = rdat_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        rsp_multi_d = rsp_multi_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;

        case (state_q)
            IDLE: begin
                if (rx_valid && ((rx_data == CMD_WRITE) || (rx_data == CMD_READ))) begin
                    is_write_d = (rx_data == CMD_WRITE);
                    byte_cnt_d = 2'd0;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                if (rx_valid) begin
                    adr_d      = {adr_q[23:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (is_write_q) begin
                            state_d = DATA;
                        end else begin
                            state_d = BUS;
                            cyc_d   = 1'b1;
                            we_d    = 1'b0;
                            sel_d   = 4'hF;
                        end
                    end
                end else if (gap_expire) begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    wdat_d     = {wdat_q[23:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = BUS;
                        cyc_d   = 1'b1;
                        we_d    = 1'b1;
                        sel_d   = 4'hF;
                    end
                end else if (gap_expire) begin
                    state_d = IDLE;
                end
            end
            BUS: begin
                // ack is checked first so it wins over a simultaneous err/rty.
                if (wb.wb_ack_i || wb.wb_err_i || wb.wb_rty_i || bus_expire) begin
                    cyc_d      = 1'b0;
                    we_d       = 1'b0;
                    sel_d      = 4'h0;
                    tx_valid_d = 1'b1;
                    byte_cnt_d = 2'd0;
                    state_d    = RESP;
                    if (wb.wb_ack_i && !is_write_q) begin
                        rdat_d      = wb.wb_dat_i;
                        rsp_multi_d = 1'b1;
                        tx_data_d   = wb.wb_dat_i[31:24];
                    end else begin
                        rsp_multi_d = 1'b0;
                        tx_data_d   = wb.wb_ack_i ? RSP_OK : RSP_ERR;
                    end
                end
            end
            RESP: begin
                if (tx_valid_q && tx_ready) begin
                    if (!rsp_multi_q || (byte_cnt_q == 2'd3)) begin
                        tx_valid_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        tx_data_d  = word_byte(rdat_q, byte_cnt_q + 2'd1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            is_write_q  <= 1'b0;
            byte_cnt_q  <= 2'd0;
            adr_q       <= '0;
            wdat_q      <= '0;
            rdat_q      <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'h0;
            rsp_multi_q <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            is_write_q  <= is_write_d;
            byte_cnt_q  <= byte_cnt_d;
            adr_q       <= adr_d;
            wdat_q      <= wdat_d;
            rdat_q      <= rdat_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            rsp_multi_q <= rsp_multi_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = wdat_q;
    assign wb.wb_sel_o = sel_q;
    assign wb.wb_we_o  = we_q;
    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = cyc_q;
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_wb_serial_master.sv
// tb/tb_wb_serial_master.sv - directed self-checking bench for wb_serial_master
module tb_wb_serial_master;

    localparam int SL_ACK  = 0;
    localparam int SL_ERR  = 1;
    localparam int SL_NONE = 2;
    localparam int SL_BOTH = 3;
    localparam int SL_RTY  = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int          slave_mode  = SL_ACK;
    int          slave_delay = 1;
    logic [31:0] slave_data  = 32'h0;
    int          slv_cnt     = 0;
    logic        cyc_prev    = 1'b0;
    int          bus_starts  = 0;
    int          cyc_cycles  = 0;
    logic [31:0] cap_adr     = 32'h0;
    logic [31:0] cap_dat     = 32'h0;
    logic        cap_we      = 1'b0;
    logic [3:0]  cap_sel     = 4'h0;
    logic [7:0]  tx_log[$];

    always #5 clk = ~clk;

    wb_serial_master_if bus();

    wb_serial_master #(.timeout_cycles(16), .rx_gap_cycles(10)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .wb       (bus),
        .busy     (busy)
    );

    always @(negedge clk) begin
        bus.wb_dat_i = slave_data;
        if (bus.wb_cyc_o && bus.wb_stb_o) begin
            if (!cyc_prev) begin
                bus_starts = bus_starts + 1;
                cap_adr = bus.wb_adr_o;
                cap_dat = bus.wb_dat_o;
                cap_we  = bus.wb_we_o;
                cap_sel = bus.wb_sel_o;
            end
            cyc_cycles = cyc_cycles + 1;
            slv_cnt = slv_cnt + 1;
            if (slv_cnt == slave_delay) begin
                bus.wb_ack_i = (slave_mode == SL_ACK) || (slave_mode == SL_BOTH);
                bus.wb_err_i = (slave_mode == SL_ERR) || (slave_mode == SL_BOTH);
                bus.wb_rty_i = (slave_mode == SL_RTY);
            end else begin
                bus.wb_ack_i = 1'b0;
                bus.wb_err_i = 1'b0;
                bus.wb_rty_i = 1'b0;
            end
        end else begin
            slv_cnt = 0;
            bus.wb_ack_i = 1'b0;
            bus.wb_err_i = 1'b0;
            bus.wb_rty_i = 1'b0;
        end
        cyc_prev = bus.wb_cyc_o;
        if (tx_valid && tx_ready) tx_log.push_back(tx_data);
    end

    task automatic send_bytes(input int n, input logic [71:0] v);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rx_data  = v[8*(n-1-i) +: 8];
            rx_valid = 1'b1;
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle timeout: busy=%b required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({tx_valid, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b required 00000",
                     {tx_valid, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, busy});
        end
        checks++;
        if ({bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o, tx_data} !== 76'h0) begin
            errors++;
            $display("FAIL reset_data adr=%h dat=%h sel=%h tx=%h required 0",
                     bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o, tx_data);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_write();
        int b0, s0;
        b0 = bus_starts; s0 = tx_log.size();
        slave_mode = SL_ACK; slave_delay = 2;
        send_bytes(9, 72'h57_00001000_DEADBEEF);
        checks++;
        if (bus.wb_cyc_o !== 1'b1) begin
            errors++;
            $display("FAIL write_latency cyc=%b required 1", bus.wb_cyc_o);
        end
        wait_idle("write");
        checks++;
        if (bus_starts - b0 !== 1) begin
            errors++;
            $display("FAIL write_cycles got %0d required 1", bus_starts - b0);
        end
        checks++;
        if ({cap_adr, cap_dat, cap_we, cap_sel} !== {32'h00001000, 32'hDEADBEEF, 1'b1, 4'hF}) begin
            errors++;
            $display("FAIL write_bus adr=%h dat=%h we=%b sel=%h required 00001000 deadbeef 1 f",
                     cap_adr, cap_dat, cap_we, cap_sel);
        end
        checks++;
        if (tx_log.size() - s0 !== 1 || tx_log[s0] !== 8'h4B) begin
            errors++;
            $display("FAIL write_rsp count=%0d required 1 byte 4b", tx_log.size() - s0);
        end
    endtask

    task automatic test_read_stall();
        logic [31:0] exp;
        int s0, g;
        exp = 32'h12345678;
        s0 = tx_log.size();
        slave_mode = SL_ACK; slave_delay = 1; slave_data = exp;
        tx_ready = 1'b0;
        send_bytes(5, 72'h52_F0000004);
        g = 0;
        @(negedge clk);
        while (!tx_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        for (int k = 0; k < 4; k++) begin
            for (int s = 0; s < 5; s++) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== exp[8*(3-k) +: 8]) begin
                    errors++;
                    $display("FAIL read_hold byte%0d valid=%b data=%h required 1 %h",
                             k, tx_valid, tx_data, exp[8*(3-k) +: 8]);
                end
                @(negedge clk);
            end
            @(posedge clk); #1 tx_ready = 1'b1;
            @(posedge clk); #1 tx_ready = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_valid_drop got %b required 0", tx_valid);
        end
        checks++;
        if (cap_we !== 1'b0 || cap_adr !== 32'hF0000004) begin
            errors++;
            $display("FAIL read_bus we=%b adr=%h required 0 f0000004", cap_we, cap_adr);
        end
        checks++;
        if (tx_log.size() - s0 !== 4 || {tx_log[s0], tx_log[s0+1], tx_log[s0+2], tx_log[s0+3]} !== exp) begin
            errors++;
            $display("FAIL read_bytes count=%0d required 4 bytes 12345678", tx_log.size() - s0);
        end
        tx_ready = 1'b1;
        wait_idle("read");
    endtask

    task automatic test_error(input int mode, input int exp_cyc, input string name);
        int c0, s0;
        c0 = cyc_cycles; s0 = tx_log.size();
        slave_mode = mode; slave_delay = 1;
        send_bytes(5, 72'h52_00000040);
        wait_idle(name);
        checks++;
        if (cyc_cycles - c0 !== exp_cyc) begin
            errors++;
            $display("FAIL %s_cyc_len got %0d required %0d", name, cyc_cycles - c0, exp_cyc);
        end
        checks++;
        if (tx_log.size() - s0 !== 1 || tx_log[s0] !== 8'h45) begin
            errors++;
            $display("FAIL %s_rsp count=%0d required 1 byte 45", name, tx_log.size() - s0);
        end
    endtask

    task automatic test_junk_gap();
        int b0, s0;
        b0 = bus_starts; s0 = tx_log.size();
        send_bytes(3, 72'h00_FF_41);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus_starts != b0) begin
            errors++;
            $display("FAIL junk busy=%b cycles=%0d required 0 0", busy, bus_starts - b0);
        end
        send_bytes(2, 72'h52_00);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL gap_partial busy=%b required 1", busy);
        end
        repeat (15) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus_starts != b0) begin
            errors++;
            $display("FAIL gap_expire busy=%b cycles=%0d required 0 0", busy, bus_starts - b0);
        end
        slave_mode = SL_ACK; slave_delay = 1; slave_data = 32'hA5A50F0F;
        send_bytes(5, 72'h52_00000100);
        wait_idle("gap_read");
        checks++;
        if (tx_log.size() - s0 !== 4 || {tx_log[s0], tx_log[s0+1], tx_log[s0+2], tx_log[s0+3]} !== 32'hA5A50F0F) begin
            errors++;
            $display("FAIL gap_read count=%0d required 4 bytes a5a50f0f", tx_log.size() - s0);
        end
    endtask

    task automatic test_reset_mid_cycle();
        int s0;
        s0 = tx_log.size();
        slave_mode = SL_NONE;
        send_bytes(5, 72'h52_00000200);
        @(posedge clk); #1 reset_n = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        checks++;
        if ({bus.wb_cyc_o, bus.wb_stb_o, tx_valid, busy, bus.wb_sel_o} !== 8'h00 || bus.wb_adr_o !== 32'h0) begin
            errors++;
            $display("FAIL midreset_outputs cyc=%b stb=%b txv=%b busy=%b adr=%h required all 0",
                     bus.wb_cyc_o, bus.wb_stb_o, tx_valid, busy, bus.wb_adr_o);
        end
        repeat (30) @(negedge clk);
        checks++;
        if (tx_log.size() != s0) begin
            errors++;
            $display("FAIL midreset_no_tx got %0d bytes required 0", tx_log.size() - s0);
        end
        slave_mode = SL_ACK; slave_delay = 1;
        send_bytes(9, 72'h57_00000300_00000001);
        wait_idle("midreset_next");
        checks++;
        if (tx_log.size() - s0 !== 1 || tx_log[s0] !== 8'h4B) begin
            errors++;
            $display("FAIL midreset_next count=%0d required 1 byte 4b", tx_log.size() - s0);
        end
    endtask

    task automatic test_ack_err();
        int s0;
        s0 = tx_log.size();
        slave_mode = SL_BOTH; slave_delay = 1; slave_data = 32'hCAFEF00D;
        send_bytes(5, 72'h52_00000400);
        wait_idle("ack_err");
        checks++;
        if (tx_log.size() - s0 !== 4 || {tx_log[s0], tx_log[s0+1], tx_log[s0+2], tx_log[s0+3]} !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL ack_err_prio count=%0d required 4 bytes cafef00d", tx_log.size() - s0);
        end
    endtask

    initial begin
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        test_reset();
        test_write();
        test_read_stall();
        test_error(SL_ERR, 1, "err");
        test_error(SL_RTY, 1, "rty");
        test_error(SL_NONE, 16, "timeout");
        test_junk_gap();
        test_reset_mid_cycle();
        test_ack_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_serial_master.md
Name: wb_serial_master

Overview:
- Wishbone initiator driven by a byte-stream command protocol. Lets a host load and inspect memory over serial without the CPU.
- Sits between a UART byte receiver/transmitter pair and master port m2 of the Wishbone interconnect (the port currently tied off).
- Parses read and write commands, runs single 32-bit Wishbone classic cycles and returns status or read data as bytes.

Parameters:
- timeout_cycles, 1024: clock cycles to wait for ack/err/rty before the block aborts a bus cycle.
- rx_gap_cycles, 100000: maximum idle cycles between bytes of one command; when exceeded, the parser returns to IDLE.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  single-cycle strobe; rx_data is valid. There is no backpressure.
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data is valid; the byte transfers on a cycle where tx_valid && tx_ready
- tx_ready  in  1  transmitter can accept a byte
- wb_adr_o  out  32  Wishbone address
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data
- wb_sel_o  out  4  byte select
- wb_we_o  out  1  write enable
- wb_cyc_o  out  1  cycle
- wb_stb_o  out  1  strobe
- wb_ack_i  in  1  acknowledge
- wb_err_i  in  1  error
- wb_rty_i  in  1  retry (treated as error)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset_n low at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0: tx_valid, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, tx_data, busy.
  - Reset during a bus cycle drops cyc/stb on the next edge. The aborted cycle sends no response.
- Command format (all multi-byte fields MSB first):
  - Write: 0x57 ('W'), 4 address bytes, 4 data bytes. Response is 0x4B ('K') on ack, 0x45 ('E') on err/rty/timeout.
  - Read: 0x52 ('R'), 4 address bytes. Response is 4 data bytes MSB first on ack, or the single byte 0x45 on failure.
  - Any other byte in IDLE is ignored.
- State machine:
  - IDLE: on rx_valid with 'W' or 'R', latch the command and clear byte_cnt, then go to ADDR.
  - ADDR: shift each rx byte into the address register. After the 4th byte, a write goes to DATA and a read goes to BUS.
  - DATA: shift 4 bytes into the write-data register, then go to BUS.
  - BUS:
    - Assert cyc=stb=1, sel=4'hF, and we=1 for writes. Clear the timeout counter.
    - Hold cyc/stb until the first of ack, err, rty, or the counter reaching timeout_cycles-1.
    - Deassert cyc/stb on the cycle after the terminating condition is sampled (registered outputs).
    - On read ack, capture wb_dat_i in the same cycle.
    - ack takes priority over err/rty when both are asserted in the same cycle.
    - Then go to RESP.
  - RESP:
    - Present the bytes one at a time; tx_data stays stable while tx_valid is high.
    - Advance to the next byte only on tx_valid && tx_ready.
    - After the last byte (1 byte for status, 4 for read data), return to IDLE.
    - tx_valid drops in the cycle after the last transfer.
- rx bytes received in BUS or RESP are discarded.
- Gap counter:
  - Runs in ADDR and DATA; rx_valid resets it.
  - When it reaches rx_gap_cycles-1, the partial command is discarded and the state returns to IDLE.
  - If rx_valid and expiry happen in the same cycle, the byte wins.
- Width rules: byte_cnt is 2 bits and wraps naturally. The timeout and gap counters are sized with $clog2 of their parameters and never wrap (they saturate, then trigger).
- Latency: first bus strobe 1 cycle after the last command byte is accepted. First tx_valid 1 cycle after ack.
- No pipelining or burst cycles: CTI is not driven, so the interconnect treats every cycle as classic.

Decomposition:
- Shared package/include holds:
  - Command constants: CMD_WRITE=8'h57, CMD_READ=8'h52, RSP_OK=8'h4B, RSP_ERR=8'h45.
  - State encoding: IDLE, ADDR, DATA, BUS, RESP.
- One sub-module, wb_serial_timer: a saturating counter with clear and expire outputs, instantiated twice (bus timeout, rx gap).
- Everything else lives in a single FSM file.

Test Plan:
- Write with immediate ack: send 57 00 00 10 00 DE AD BE EF with a slave that acks after 2 cycles -> one cycle with adr=0x00001000, dat_o=0xDEADBEEF, we=1, sel=F; exactly one tx byte 0x4B.
- Read: send 52 F0 00 00 04 with a slave returning 0x12345678 -> we=0 cycle at 0xF0000004; tx bytes 12 34 56 78 in order; tx_ready held low for 5 cycles between bytes holds tx_data stable.
- Error/timeout:
  - Slave asserts err -> tx 0x45, cyc drops within 1 cycle.
  - No response, timeout_cycles=16 -> cyc high for exactly 16 cycles, then tx 0x45.
- Junk and gap: bytes 00 FF 41 ignored (no cyc). Sending 52 00 then going silent for rx_gap_cycles (10 in the bench) returns busy to 0 with no bus cycle. A following full read works.
- Reset mid-cycle: reset_n low for 1 cycle while cyc=1 -> on the next edge all outputs are 0, no tx byte is sent, and the next command executes normally.
- Simultaneous ack+err on a read -> treated as ack: 4 data bytes returned.
